hazard_scoreboard: RTL and testbench

Decode-stage hazard consumer for the five-stage MIPS pipeline. Per-stage control units announce each instruction's destination register and Tnew. This block takes those announcements at issue and tracks them itself through an E/M/W shadow pipeline, decrementing Tnew each cycle. It compares the shadow entries against the decoding instruction's source registers and Tuse, and produces the stall signal and the D-stage forward selects. It also owns the HI/LO multiply/divide busy counter that stalls MD-class instructions.

---
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations through an E/M/W shadow pipeline,
// produces the D-stage stall and forward selects, and owns the HI/LO multiply/divide busy counter.
module hazard_scoreboard #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fw_rs_sel,
    output logic [1:0] fw_rt_sel,
    output logic       md_busy
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYC);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYC);

    // Index 0 = E, 1 = M, 2 = W; the stage code used for forwarding is index + 1.
    logic [2:0] valid_q;
    logic [4:0] dst_q  [3];
    logic [1:0] tnew_q [3];
    logic [3:0] md_cnt_q;

    logic       rs_stall, rt_stall, md_stall;
    logic [1:0] rs_sel, rt_sel;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Returns {stall, forward select} for one source operand.
    function automatic logic [2:0] resolve(input logic [4:0] src, input logic [1:0] tuse,
                                           input logic [2:0] v, input logic [4:0] dst [3],
                                           input logic [1:0] tnew [3]);
        logic       hit;
        logic [1:0] t;
        logic [1:0] code;
        hit  = 1'b0;
        t    = 2'd0;
        code = 2'd0;
        // Walk W -> E so the nearest matching stage overrides older ones.
        for (int i = 2; i >= 0; i--) begin
            if (v[i] && dst[i] == src) begin
                hit  = 1'b1;
                t    = tnew[i];
                code = 2'(i + 1);
            end
        end
        if (tuse == 2'd3 || src == 5'd0 || !hit) begin
            return 3'b000;
        end
        return {t > tuse, (t == 2'd0) ? code : 2'd0};
    endfunction

    always_comb begin
        {rs_stall, rs_sel} = resolve(d_rs, d_tuse_rs, valid_q, dst_q, tnew_q);
        {rt_stall, rt_sel} = resolve(d_rt, d_tuse_rt, valid_q, dst_q, tnew_q);
        md_busy   = (md_cnt_q != 4'd0);
        md_stall  = d_md_use && md_busy;
        stall     = rs_stall | rt_stall | md_stall;
        fw_rs_sel = rs_sel;
        fw_rt_sel = rt_sel;
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid_q  <= 3'b000;
            md_cnt_q <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                dst_q[i]  <= 5'd0;
                tnew_q[i] <= 2'd0;
            end
        end else begin
            valid_q[2] <= valid_q[1];
            dst_q[2]   <= dst_q[1];
            tnew_q[2]  <= sat_dec(tnew_q[1]);
            valid_q[1] <= valid_q[0];
            dst_q[1]   <= dst_q[0];
            tnew_q[1]  <= sat_dec(tnew_q[0]);
            // A stalled D instruction leaves a bubble in E.
            valid_q[0] <= !stall;
            dst_q[0]   <= stall ? 5'd0 : d_dst;
            tnew_q[0]  <= stall ? 2'd0 : d_tnew;
            if (!stall && d_md_start) begin
                md_cnt_q <= d_md_div ? DivLoad : MultLoad;
            end else if (md_cnt_q != 4'd0) begin
                md_cnt_q <= md_cnt_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic, checked
// against an in-flight instruction list model with issue ages.
module tb_hazard_scoreboard;

    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use, flush;
    logic       stall, md_busy;
    logic [1:0] fw_rs_sel, fw_rt_sel;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .flush      (flush),
        .stall      (stall),
        .fw_rs_sel  (fw_rs_sel),
        .fw_rt_sel  (fw_rt_sel),
        .md_busy    (md_busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: every issued instruction with its destination, issue-time Tnew and cycles since issue
    // (age 1 = in E, 2 = M, 3 = W). Remaining Tnew = max(0, tnew - (age - 1)).
    typedef struct {
        int dst;
        int tnew;
        int age;
    } ent_t;
    ent_t inflight[$];
    int   cyc       = 0;
    int   md_issue  = -100;
    int   md_len    = 0;

    function automatic void ref_src(input int s, input int tuse, output int st, output int sel);
        int best;
        int rem;
        best = -1;
        st   = 0;
        sel  = 0;
        if (tuse == 3 || s == 0) return;
        foreach (inflight[i]) begin
            if (inflight[i].dst == s && (best < 0 || inflight[i].age < inflight[best].age))
                best = i;
        end
        if (best < 0) return;
        rem = inflight[best].tnew - (inflight[best].age - 1);
        if (rem < 0) rem = 0;
        st  = (rem > tuse) ? 1 : 0;
        sel = (rem == 0) ? inflight[best].age : 0;
    endfunction

    function automatic int ref_busy();
        return ((cyc - md_issue) >= 1 && (cyc - md_issue) <= md_len) ? 1 : 0;
    endfunction

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input int tur, input int tut, input int dst,
                         input int tnew, input int mds = 0, input int mdd = 0, input int mdu = 0,
                         input int fl = 0, input int rst = 1);
        d_rs       = 5'(rs);
        d_rt       = 5'(rt);
        d_tuse_rs  = 2'(tur);
        d_tuse_rt  = 2'(tut);
        d_dst      = 5'(dst);
        d_tnew     = 2'(tnew);
        d_md_start = 1'(mds);
        d_md_div   = 1'(mdd);
        d_md_use   = 1'(mdu);
        flush      = 1'(fl);
        reset      = 1'(rst);
    endtask

    task automatic nop();
        drive(0, 0, 3, 3, 0, 0);
    endtask

    // One cycle: compare outputs with the model (and with given constants; -1 = skip),
    // then advance the model across the rising edge.
    task automatic tick(input string tag, input int c_st, input int c_rs, input int c_rt,
                        input int c_busy);
        int rs_st, rs_sel, rt_st, rt_sel, busy, st;
        @(negedge clk);
        ref_src(int'(d_rs), int'(d_tuse_rs), rs_st, rs_sel);
        ref_src(int'(d_rt), int'(d_tuse_rt), rt_st, rt_sel);
        busy = ref_busy();
        st   = (rs_st != 0 || rt_st != 0 || (d_md_use && busy != 0)) ? 1 : 0;
        cmp({tag, ".stall"}, 4'(stall), 4'(st));
        cmp({tag, ".fw_rs"}, 4'(fw_rs_sel), 4'(rs_sel));
        cmp({tag, ".fw_rt"}, 4'(fw_rt_sel), 4'(rt_sel));
        cmp({tag, ".md_busy"}, 4'(md_busy), 4'(busy));
        if (c_st >= 0)   cmp({tag, ".stall_k"}, 4'(stall), 4'(c_st));
        if (c_rs >= 0)   cmp({tag, ".fw_rs_k"}, 4'(fw_rs_sel), 4'(c_rs));
        if (c_rt >= 0)   cmp({tag, ".fw_rt_k"}, 4'(fw_rt_sel), 4'(c_rt));
        if (c_busy >= 0) cmp({tag, ".md_busy_k"}, 4'(md_busy), 4'(c_busy));
        @(posedge clk);
        if (!reset || flush) begin
            inflight.delete();
            md_len = 0;
        end else begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                inflight[i].age++;
                if (inflight[i].age > 3) inflight.delete(i);
            end
            if (st == 0) begin
                inflight.push_back('{dst: int'(d_dst), tnew: int'(d_tnew), age: 1});
                if (d_md_start) begin
                    md_issue = cyc;
                    md_len   = d_md_div ? DIV_CYC : MULT_CYC;
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held with arbitrary inputs.
        drive(7, 9, 0, 1, 4, 2, 1, 1, 1, 0, 0);
        tick("reset0", 0, 0, 0, 0);
        drive(3, 3, 0, 0, 3, 1, 0, 0, 1, 1, 0);
        tick("reset1", 0, 0, 0, 0);

        // add $3 enters E with tnew 1.
        drive(0, 0, 3, 3, 3, 1);
        tick("add3", 0, 0, 0, 0);
        drive(3, 0, 0, 3, 0, 0);
        tick("add3_e", 1, 0, 0, 0);
        drive(3, 0, 1, 3, 0, 0);
        tick("add3_m", 0, 2, 0, 0);

        // Load-use: lw $8 then beq on $8.
        drive(0, 0, 3, 3, 8, 2);
        tick("lw8", 0, 0, 0, 0);
        drive(8, 0, 0, 3, 0, 0);
        tick("lu_e", 1, 0, 0, 0);
        tick("lu_m", 1, 0, 0, 0);
        tick("lu_w", 0, 3, 0, 0);

        // ALU forward from E (deferred) then M.
        drive(0, 0, 3, 3, 5, 1);
        tick("addu5", 0, 0, 0, 0);
        drive(0, 5, 3, 1, 0, 0);
        tick("alu_e", 0, 0, 0, 0);
        tick("alu_m", 0, 0, 2, 0);

        // Nearest match wins: E ($4, tnew 1) beats M ($4, tnew 0).
        drive(0, 0, 3, 3, 4, 1);
        tick("ori4", 0, 0, 0, 0);
        tick("lui4", 0, 0, 0, 0);
        drive(4, 0, 1, 3, 0, 0);
        tick("near", 0, 0, 0, 0);

        // Divide then mflo.
        drive(0, 0, 3, 3, 0, 0, 1, 1, 1);
        tick("div", 0, 0, 0, 0);
        drive(0, 0, 3, 3, 2, 1, 0, 0, 1);
        for (int k = 0; k < int'(DIV_CYC); k++) tick("div_wait", 1, 0, 0, 1);
        tick("div_done", 0, 0, 0, 0);

        // Multiply then mflo.
        drive(0, 0, 3, 3, 0, 0, 1, 0, 1);
        tick("mult", 0, 0, 0, 0);
        drive(0, 0, 3, 3, 2, 1, 0, 0, 1);
        for (int k = 0; k < int'(MULT_CYC); k++) tick("mult_wait", 1, 0, 0, 1);
        tick("mult_done", 0, 0, 0, 0);

        // Flush mid-division with D stalled.
        drive(0, 0, 3, 3, 9, 2);
        tick("lw9", 0, 0, 0, 0);
        drive(0, 0, 3, 3, 0, 0, 1, 1, 1);
        tick("div2", 0, 0, 0, 0);
        drive(9, 0, 0, 3, 2, 1, 0, 0, 1);
        tick("pre_flush", 1, 0, 0, 1);
        drive(9, 0, 0, 3, 2, 1, 0, 0, 1, 1);
        tick("flush", 1, 3, 0, 1);
        drive(9, 0, 0, 3, 2, 1, 0, 0, 1);
        tick("post_flush", 0, 0, 0, 0);

        // $0 destination in E never matches.
        drive(0, 0, 3, 3, 0, 2);
        tick("dst0", 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick("read0", 0, 0, 0, 0);
        nop();
        tick("nop", 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int mds;
            mds = ($urandom_range(0, 11) == 0) ? 1 : 0;
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2), mds,
                  $urandom_range(0, 1), (mds != 0 || $urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 29) == 0) ? 1 : 0, ($urandom_range(0, 49) == 0) ? 0 : 1);
            tick("rand", -1, -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
